nmr_bstrm_seq_dpath: RTL and testbench
======================================

# nmr_bstrm_seq_dpath

Multi-channel, table-driven successor to the single-pulse bitstream datapath. Plays a programmed sequence of up to DEPTH pulse entries, each a length and an NCH-bit level vector, gap-free on NCH parallel bitstream outputs, and repeats the sequence a programmable number of times. Sits between the control/register interface and the NMR TX gate/phase lines. Lets a whole pulse train, such as a CPMG echo block, run from one START without per-pulse software handshakes.

## Interface
- DATA_WIDTH, 32, pulse length width in clock cycles
- NCH, 4, number of output channels
- DEPTH, 8, table entries; power of 2, ≥2; AW = log2(DEPTH)
- LOOP_WIDTH, 16, repeat-count width

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- prog_we  in  1  table write strobe
- prog_addr  in  AW  table write address
- prog_len  in  DATA_WIDTH  entry length in cycles
- prog_lvl  in  NCH  entry output levels
- n_entries  in  AW+1  entries per pass; legal range 1..DEPTH
- n_loops  in  LOOP_WIDTH  extra passes; total passes = n_loops+1
- idle_lvl  in  NCH  output levels while idle
- START  in  1  start request, level-sampled
- DPATH_RDY  out  1  high in IDLE
- DONE  out  1  one-cycle pulse at sequence end
- ERR  out  1  one-cycle pulse on illegal START
- OUT  out  NCH  bitstream outputs, registered

## Operation
- States: IDLE, LOAD, RUN.
- Reset values: state IDLE, OUT = 0, DPATH_RDY = 1, DONE = 0, ERR = 0, all counters 0. Reset does not clear the table.
- IDLE: OUT <= idle_lvl every cycle, with 1-cycle registered follow. A table write occurs when prog_we = 1. START is accepted when n_entries is in 1..DEPTH.
- Accepted START: latches n_entries and n_loops, sets entry index to 0 and pass counter to 0, issues the read of entry 0, then goes to LOAD.
- Illegal START (n_entries = 0 or > DEPTH): ERR pulses for 1 cycle and the state stays IDLE.
- LOAD: one cycle for the synchronous table read. Then OUT <= lvl[0], the length counter loads, and the state goes to RUN.
- RUN: entry i drives lvl[i] for exactly max(len[i],1) cycles, so len = 0 is treated as 1. The next entry is prefetched so consecutive entries are back-to-back with no idle cycle.
- After entry n_entries−1:
  - If pass < n_loops: wrap to entry 0 and increment pass.
  - Otherwise: OUT <= idle_lvl, DONE = 1 for one cycle, DPATH_RDY = 1, state goes to IDLE.
- Length counter is DATA_WIDTH bits and counts down. Pass counter is LOOP_WIDTH bits and compares against the latched n_loops. No overflow is possible.
- Outside IDLE:
  - prog_we is ignored; the table is frozen during a run.
  - START is ignored.
  - Changes on n_entries, n_loops and idle_lvl have no effect.
- RST asserted mid-run: immediate return to IDLE, OUT = 0, no DONE.

## Timing
- START is sampled high in IDLE at edge k. DPATH_RDY is low after edge k, and the state is LOAD in the cycle after k.
- OUT = lvl[0] from edge k+2.
- For a sequence total of T cycles, T = (n_loops+1)·Σ max(len[i],1):
  - OUT = idle_lvl from edge k+2+T.
  - DONE is high in the cycle after edge k+2+T.
  - DPATH_RDY is high from edge k+2+T.
- A new START sampled at edge k+2+T or later is accepted. START held high continuously therefore restarts immediately, with a 2-cycle idle gap (DONE cycle plus LOAD).
- A table write at edge w is visible to a START sampled at edge w+1 or later.
- ERR is asserted in the cycle after the illegal START edge.

## Test plan
- Reset mid-run: assert RST during entry 0 of any run → OUT = 0 and DPATH_RDY = 1 asynchronously, no DONE. Next START replays the table unchanged.
- Basic single entry: table {len 5, lvl 0001}, n_entries=1, n_loops=0, idle_lvl=0000, START at edge k → OUT = 0001 for edges k+2..k+6, OUT = 0000 at k+7, DONE pulse once, DPATH_RDY returns high.
- Gapless loop: table {5,0001},{3,0010}, n_entries=2, n_loops=1 → OUT sequence 0001×5, 0010×3, 0001×5, 0010×3 (16 cycles, no idle cycle), then DONE.
- Minimum lengths: four entries of len 1 and len 0 with distinct levels, n_loops=2 → each level for exactly 1 cycle, 12 cycles total, DONE once.
- Illegal/ignored inputs:
  - START with n_entries=0 → ERR pulse, DPATH_RDY stays high, OUT unchanged.
  - n_entries=DEPTH+1 → same.
  - START and prog_we during RUN → no effect on OUT or table contents.
- Back-to-back and idle level: START held high with idle_lvl=1010 → two full runs separated by exactly 2 cycles with OUT=1010, one DONE per run.

Source files
------------

// File: rtl/nmr_bstrm_seq_dpath_if.sv
// rtl/nmr_bstrm_seq_dpath_if.sv - control/program/output bundle for the pulse-table bitstream datapath
interface nmr_bstrm_seq_dpath_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NCH        = 4,
  parameter int DEPTH      = 8,
  parameter int LOOP_WIDTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  prog_we;
  logic [AW-1:0]         prog_addr;
  logic [DATA_WIDTH-1:0] prog_len;
  logic [NCH-1:0]        prog_lvl;
  logic [AW:0]           n_entries;
  logic [LOOP_WIDTH-1:0] n_loops;
  logic [NCH-1:0]        idle_lvl;
  logic                  START;
  logic                  DPATH_RDY;
  logic                  DONE;
  logic                  ERR;
  logic [NCH-1:0]        OUT;

  modport master (
    output prog_we, prog_addr, prog_len, prog_lvl,
    output n_entries, n_loops, idle_lvl, START,
    input  DPATH_RDY, DONE, ERR, OUT
  );

  modport slave (
    input  prog_we, prog_addr, prog_len, prog_lvl,
    input  n_entries, n_loops, idle_lvl, START,
    output DPATH_RDY, DONE, ERR, OUT
  );
endinterface

// File: rtl/nmr_bstrm_seq_dpath.sv
// rtl/nmr_bstrm_seq_dpath.sv - table-driven multi-channel pulse sequencer with gap-free entries and pass repeat
module nmr_bstrm_seq_dpath #(
  parameter int DATA_WIDTH = 32,
  parameter int NCH        = 4,
  parameter int DEPTH      = 8,
  parameter int LOOP_WIDTH = 16
) (
  input logic                  CLK,
  input logic                  RST,
  nmr_bstrm_seq_dpath_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [DATA_WIDTH-1:0] len_mem [DEPTH];
  logic [NCH-1:0]        lvl_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_len_q;
  logic [NCH-1:0]        rd_lvl_q;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [LOOP_WIDTH-1:0] pass_q, pass_d;
  logic [LOOP_WIDTH-1:0] nloop_q, nloop_d;
  logic [AW:0]           nent_q, nent_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  fin_q, fin_d;
  logic [NCH-1:0]        idle_q, idle_d;
  logic [NCH-1:0]        out_q, out_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic legal;
  logic entry_end;
  logic last_entry;
  logic accept;

  assign legal      = (bus.n_entries != '0) && (bus.n_entries <= DEPTH_V);
  assign entry_end  = (cnt_q <= DATA_WIDTH'(1));
  assign last_entry = ({1'b0, idx_q} == (nent_q - (AW+1)'(1)));

  // A START present on the final edge of a run chains straight into LOAD,
  // so a held START restarts with only the DONE and LOAD cycles between runs.
  assign accept = bus.START && legal &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_RUN) && entry_end && fin_q));

  // idx_q names the entry sitting in rd_*_q, one ahead of what OUT shows.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    nloop_d = nloop_q;
    nent_d  = nent_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    idle_d  = idle_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      ST_IDLE: begin
        out_d = bus.idle_lvl;
        err_d = bus.START && !legal;
      end
      ST_LOAD: begin
        rd_en   = 1'b1;
        cnt_d   = '0;
        fin_d   = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!entry_end) begin
          cnt_d = cnt_q - DATA_WIDTH'(1);
        end else if (fin_q) begin
          out_d   = idle_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          out_d = rd_lvl_q;
          cnt_d = (rd_len_q == '0) ? DATA_WIDTH'(1) : rd_len_q;
          rd_en = 1'b1;
          if (!last_entry) begin
            idx_d   = idx_q + AW'(1);
            rd_addr = idx_q + AW'(1);
          end else if (pass_q != nloop_q) begin
            idx_d  = '0;
            pass_d = pass_q + LOOP_WIDTH'(1);
          end else begin
            fin_d = 1'b1;
            rd_en = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_LOAD;
      nent_d  = bus.n_entries;
      nloop_d = bus.n_loops;
      idle_d  = bus.idle_lvl;
      idx_d   = '0;
      pass_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      nloop_q <= '0;
      nent_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      idle_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      nloop_q <= nloop_d;
      nent_q  <= nent_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      idle_q  <= idle_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Table survives reset and is frozen while a sequence is active.
  always_ff @(posedge CLK) begin
    if ((state_q == ST_IDLE) && bus.prog_we) begin
      len_mem[bus.prog_addr] <= bus.prog_len;
      lvl_mem[bus.prog_addr] <= bus.prog_lvl;
    end
    if (rd_en) begin
      rd_len_q <= len_mem[rd_addr];
      rd_lvl_q <= lvl_mem[rd_addr];
    end
  end

  assign bus.OUT       = out_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.DPATH_RDY = (state_q == ST_IDLE);
endmodule

// File: tb/tb_nmr_bstrm_seq_dpath.sv
// tb/tb_nmr_bstrm_seq_dpath.sv - self-checking bench for nmr_bstrm_seq_dpath
module tb_nmr_bstrm_seq_dpath;
  localparam int DW    = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int LW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nmr_bstrm_seq_dpath_if #(.DATA_WIDTH(DW), .NCH(NCH), .DEPTH(DEPTH), .LOOP_WIDTH(LW)) bus ();

  nmr_bstrm_seq_dpath #(.DATA_WIDTH(DW), .NCH(NCH), .DEPTH(DEPTH), .LOOP_WIDTH(LW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         tbl_len [DEPTH];
  logic [3:0] tbl_lvl [DEPTH];
  logic [3:0] exp_q [$];

  typedef struct {
    int         ne;
    int         nl;
    logic [3:0] idle;
    bit         exp_err;
    int         exp_t;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected OUT stream: every pass plays every entry for max(len,1) cycles.
  function automatic void build_model(input int ne, input int nl);
    exp_q.delete();
    for (int p = 0; p <= nl; p++)
      for (int i = 0; i < ne; i++)
        for (int c = 0; c < ((tbl_len[i] == 0) ? 1 : tbl_len[i]); c++)
          exp_q.push_back(tbl_lvl[i]);
  endfunction

  task automatic prog(input int a, input int len, input logic [3:0] lvl);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a[2:0];
    bus.prog_len  = len;
    bus.prog_lvl  = lvl;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    tbl_len[a] = len;
    tbl_lvl[a] = lvl;
  endtask

  task automatic run_seq(input int ne, input int nl, input logic [3:0] idle,
                         input int exp_t, input bit disturb, input string tag);
    int    t;
    int    mism;
    int    errs;
    string first_bad;
    build_model(ne, nl);
    mism = 0;
    errs = 0;
    first_bad = "";
    @(negedge clk);
    bus.n_entries = ne[3:0];
    bus.n_loops   = nl[15:0];
    bus.idle_lvl  = idle;
    bus.START     = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    check({tag, "_rdy_low"}, bus.DPATH_RDY, 0);
    check({tag, "_out_load"}, bus.OUT, idle);
    @(negedge clk);
    for (t = 0; t < exp_t + 4; t++) begin
      @(negedge clk);
      if (bus.DONE) break;
      errs += bus.ERR;
      if (t >= exp_q.size() || bus.OUT !== exp_q[t]) begin
        if (mism == 0)
          first_bad = $sformatf("_t%0d_out%0h_exp%0h", t, bus.OUT,
                                (t < exp_q.size()) ? exp_q[t] : 4'h0);
        mism++;
      end
      if (disturb && t == 0) begin
        bus.START     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd0;
        bus.prog_len  = 7;
        bus.prog_lvl  = 4'hf;
        bus.n_entries = 4'd1;
        bus.n_loops   = 16'd5;
        bus.idle_lvl  = ~idle;
      end
      if (disturb && t == 3) begin
        bus.START   = 1'b0;
        bus.prog_we = 1'b0;
      end
    end
    check({tag, "_stream", first_bad}, mism, 0);
    check({tag, "_len"}, t, exp_t);
    check({tag, "_err_quiet"}, errs, 0);
    check({tag, "_out_idle"}, bus.OUT, idle);
    check({tag, "_done"}, bus.DONE, 1);
    check({tag, "_rdy"}, bus.DPATH_RDY, 1);
    bus.START    = 1'b0;
    bus.prog_we  = 1'b0;
    bus.idle_lvl = idle;
    @(negedge clk);
    check({tag, "_done_once"}, bus.DONE, 0);
  endtask

  task automatic err_vec(input int ne, input logic [3:0] idle, input string tag);
    @(negedge clk);
    bus.n_entries = ne[3:0];
    bus.idle_lvl  = idle;
    bus.START     = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    check({tag, "_err"}, bus.ERR, 1);
    check({tag, "_rdy"}, bus.DPATH_RDY, 1);
    check({tag, "_out"}, bus.OUT, idle);
    @(negedge clk);
    check({tag, "_err_clr"}, bus.ERR, 0);
    check({tag, "_rdy2"}, bus.DPATH_RDY, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int dones;
    int bad;
    int ne;
    int nl;
    logic [3:0] idle;

    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_len  = '0;
    bus.prog_lvl  = '0;
    bus.n_entries = '0;
    bus.n_loops   = '0;
    bus.idle_lvl  = '0;
    bus.START     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out", bus.OUT, 0);
    check("rst_rdy", bus.DPATH_RDY, 1);
    check("rst_done", bus.DONE, 0);
    check("rst_err", bus.ERR, 0);
    rst = 1'b0;

    prog(0, 5, 4'b0001);
    prog(1, 3, 4'b0010);
    prog(2, 1, 4'b0100);
    prog(3, 0, 4'b1000);
    prog(4, 2, 4'b0011);
    prog(5, 0, 4'b0101);
    prog(6, 1, 4'b0110);
    prog(7, 4, 4'b1001);

    vecs[0] = '{ne: 1, nl: 0, idle: 4'h0, exp_err: 1'b0, exp_t: 5};
    vecs[1] = '{ne: 2, nl: 1, idle: 4'h0, exp_err: 1'b0, exp_t: 16};
    vecs[2] = '{ne: 0, nl: 0, idle: 4'h6, exp_err: 1'b1, exp_t: 0};
    vecs[3] = '{ne: 9, nl: 0, idle: 4'h9, exp_err: 1'b1, exp_t: 0};
    vecs[4] = '{ne: 8, nl: 0, idle: 4'hf, exp_err: 1'b0, exp_t: 18};
    vecs[5] = '{ne: 3, nl: 2, idle: 4'h5, exp_err: 1'b0, exp_t: 27};

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_err)
        err_vec(vecs[v].ne, vecs[v].idle, $sformatf("vec%0d", v));
      else
        run_seq(vecs[v].ne, vecs[v].nl, vecs[v].idle, vecs[v].exp_t, 1'b0,
                $sformatf("vec%0d", v));
    end

    // START, prog_we and config changes mid-run, then a replay of the same table
    run_seq(2, 0, 4'h3, 8, 1'b1, "frozen");
    run_seq(2, 0, 4'h3, 8, 1'b0, "replay");

    prog(0, 1, 4'b0001);
    prog(1, 0, 4'b0010);
    prog(2, 1, 4'b0100);
    prog(3, 0, 4'b1000);
    run_seq(4, 2, 4'h0, 12, 1'b0, "minlen");

    prog(0, 5, 4'b0001);
    prog(1, 3, 4'b0010);

    // asynchronous reset during entry 0
    @(negedge clk);
    bus.n_entries = 4'd2;
    bus.n_loops   = 16'd1;
    bus.idle_lvl  = 4'h0;
    bus.START     = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_entry0", bus.OUT, 4'b0001);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out", bus.OUT, 0);
    check("mid_rst_rdy", bus.DPATH_RDY, 1);
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      dones += bus.DONE;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      dones += bus.DONE;
    end
    check("mid_rst_no_done", dones, 0);
    run_seq(2, 1, 4'h0, 16, 1'b0, "after_rst");

    // START held high: two runs separated by the DONE and LOAD cycles
    build_model(1, 0);
    dones = 0;
    bad   = 0;
    @(negedge clk);
    bus.n_entries = 4'd1;
    bus.n_loops   = 16'd0;
    bus.idle_lvl  = 4'b1010;
    bus.START     = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        dones += bus.DONE;
        if (bus.OUT !== 4'b1010) bad++;
        if (g == 0 && bus.DPATH_RDY !== 1'b0) bad++;
      end
      for (int t = 0; t < exp_q.size(); t++) begin
        @(negedge clk);
        dones += bus.DONE;
        if (bus.OUT !== exp_q[t]) bad++;
        if (r == 1) bus.START = 1'b0;
      end
    end
    check("b2b_gap_stream", bad, 0);
    check("b2b_mid_done", dones, 1);
    @(negedge clk);
    check("b2b_end_done", bus.DONE, 1);
    check("b2b_end_out", bus.OUT, 4'b1010);
    check("b2b_end_rdy", bus.DPATH_RDY, 1);

    for (int it = 0; it < 15; it++) begin
      repeat (2) prog($urandom_range(0, 7), $urandom_range(0, 5), 4'($urandom_range(0, 15)));
      ne   = $urandom_range(0, 9);
      nl   = $urandom_range(0, 2);
      idle = 4'($urandom_range(0, 15));
      if (ne == 0 || ne > DEPTH) begin
        err_vec(ne, idle, $sformatf("rnd%0d", it));
      end else begin
        build_model(ne, nl);
        run_seq(ne, nl, idle, exp_q.size(), 1'b0, $sformatf("rnd%0d", it));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
